// File: rtl/vic_ctrl_if.sv
// vic_ctrl_if: CPU register bus for the VIC controller.
//   i_we    : write strobe, single cycle
//   i_re    : read strobe, single cycle
//   i_addr  : register word index
//   i_wdata : write data
//   o_rdata : registered read data
// Signal names are as seen from the controller, so the master modport drives
// the i_* signals and the slave modport drives o_rdata.
interface vic_ctrl_if;
    logic        i_we;
    logic        i_re;
    logic [5:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (
        output i_we,
        output i_re,
        output i_addr,
        output i_wdata,
        input  o_rdata
    );

    modport slave (
        input  i_we,
        input  i_re,
        input  i_addr,
        input  i_wdata,
        output o_rdata
    );
endinterface

// File: rtl/vic_ctrl.sv
// vic_ctrl: CPU-side controller for the vectored interrupt controller.
// Holds the global enable, per-source config nibbles and the vector base, and
// sequences request -> acknowledge -> service -> end-of-interrupt between the
// interrupt detector and the CPU core.
//
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   bus (slave)        : register bus (we/re/addr/wdata/rdata)
//   i_vic_irq/addr     : dispatch request and source number from the detector
//   o_vic_busy         : detector busy input (high in PEND and SERV)
//   o_vic_en           : detector global enable (CTRL[0])
//   o_vic_cfg          : nibble i = {en, rise, fall, level} for source i
//   o_cpu_irq/i_cpu_ack: request to / acknowledge from the core
//   o_irq_id, o_vector : latched source number and its handler address
//
// Optional feature: define VIC_VECTOR_TABLE_EN to add 31 vector registers
// (VEC0-VEC30 at 0x20-0x3E) that replace the BASE + 4*id vector computation.
module vic_ctrl #(
    parameter logic [31:0] VEC_RESET = 32'h0000_0100
) (
    input  logic         i_clk,
    input  logic         i_rst,
    vic_ctrl_if.slave    bus,
    input  logic         i_vic_irq,
    input  logic [4:0]   i_vic_addr,
    output logic         o_vic_busy,
    output logic         o_vic_en,
    output logic [123:0] o_vic_cfg,
    output logic         o_cpu_irq,
    input  logic         i_cpu_ack,
    output logic [4:0]   o_irq_id,
    output logic [31:0]  o_vector
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERV,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          ctrl_en_q, ctrl_en_d;
    logic [31:0]   base_q, base_d;
    logic [123:0]  cfg_q, cfg_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [4:0]    irq_id_q, irq_id_d;
    logic          irq_prev_q;

    logic          wr_ctrl, wr_eoi, wr_base;
    logic [31:0]   rd_val;

`ifdef VIC_VECTOR_TABLE_EN
    logic [31:0]   vec_q [31];
    logic [31:0]   vec_d [31];
    logic          wr_vec;
`endif

    assign wr_ctrl = bus.i_we && (bus.i_addr == 6'h00);
    assign wr_eoi  = bus.i_we && (bus.i_addr == 6'h02);
    assign wr_base = bus.i_we && (bus.i_addr == 6'h03);
`ifdef VIC_VECTOR_TABLE_EN
    assign wr_vec  = bus.i_we && bus.i_addr[5] && (bus.i_addr[4:0] != 5'd31);
`endif

    // Register file next-state
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        base_d    = base_q;
        cfg_d     = cfg_q;
        if (wr_ctrl) ctrl_en_d = bus.i_wdata[0];
        if (wr_base) base_d    = {bus.i_wdata[31:2], 2'b00};
        if (bus.i_we) begin
            case (bus.i_addr)
                6'h04:   cfg_d[31:0]   = bus.i_wdata;
                6'h05:   cfg_d[63:32]  = bus.i_wdata;
                6'h06:   cfg_d[95:64]  = bus.i_wdata;
                6'h07:   cfg_d[123:96] = bus.i_wdata[27:0];
                default: ;
            endcase
        end
    end

`ifdef VIC_VECTOR_TABLE_EN
    always_comb begin
        vec_d = vec_q;
        if (wr_vec) vec_d[bus.i_addr[4:0]] = {bus.i_wdata[31:2], 2'b00};
    end
`endif

    // Read mux sees pre-write register values, so a simultaneous write and
    // read returns the old contents.
    always_comb begin
        rd_val = '0;
        case (bus.i_addr)
            6'h00:   rd_val = {31'b0, ctrl_en_q};
            6'h01:   rd_val = {19'b0, irq_id_q, 6'b0,
                               (state_q == ST_SERV), (state_q == ST_PEND)};
            6'h03:   rd_val = base_q;
            6'h04:   rd_val = cfg_q[31:0];
            6'h05:   rd_val = cfg_q[63:32];
            6'h06:   rd_val = cfg_q[95:64];
            6'h07:   rd_val = {4'b0, cfg_q[123:96]};
            default: begin
`ifdef VIC_VECTOR_TABLE_EN
                if (bus.i_addr[5] && (bus.i_addr[4:0] != 5'd31))
                    rd_val = vec_q[bus.i_addr[4:0]];
`endif
            end
        endcase
        rdata_d = bus.i_re ? rd_val : rdata_q;
    end

    // Dispatch FSM next-state
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (i_vic_irq && !irq_prev_q && ctrl_en_q) begin
                    state_d  = ST_PEND;
                    irq_id_d = i_vic_addr;
                end
            end
            ST_PEND: begin
                // Ack takes priority over withdrawal and over a same-cycle EOI.
                if (i_cpu_ack)
                    state_d = ST_SERV;
                else if (wr_ctrl && !bus.i_wdata[0])
                    state_d = ST_DONE;
            end
            ST_SERV: begin
                if (wr_eoi) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ctrl_en_q  <= 1'b0;
            base_q     <= VEC_RESET;
            cfg_q      <= '0;
            rdata_q    <= '0;
            irq_id_q   <= '0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_en_q  <= ctrl_en_d;
            base_q     <= base_d;
            cfg_q      <= cfg_d;
            rdata_q    <= rdata_d;
            irq_id_q   <= irq_id_d;
            irq_prev_q <= i_vic_irq;
        end
    end

`ifdef VIC_VECTOR_TABLE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 31; i++)
                vec_q[i] <= VEC_RESET + 32'(4 * i);
        end else begin
            vec_q <= vec_d;
        end
    end

    // Source 31 has no table entry; its vector reads as 0.
    assign o_vector = (irq_id_q == 5'd31) ? '0 : vec_q[irq_id_q];
`else
    assign o_vector = base_q + {25'b0, irq_id_q, 2'b00};
`endif

    assign bus.o_rdata = rdata_q;
    assign o_vic_busy  = (state_q == ST_PEND) || (state_q == ST_SERV);
    assign o_cpu_irq   = (state_q == ST_PEND);
    assign o_vic_en    = ctrl_en_q;
    assign o_vic_cfg   = cfg_q;
    assign o_irq_id    = irq_id_q;

endmodule
